pdm_tx_modulator: RTL

- Transmit-side counterpart of the PDM microphone front end: converts signed PCM audio samples into a 1-bit pulse-density-modulated stream.
- Generates its own PDM bit clock with the same divider scheme as the mic clock: PDM_COUNT_PERIOD system cycles per bit.
- Buffers incoming samples in a small FIFO and holds each sample for OSR PDM bits.
- Drives the audio output pin, and doubles as a bit-exact PDM stimulus source for the mic/FIR decimation chain in simulation.

---
 rtl/pdm_tx_modulator_if.sv | 11 +
 rtl/pdm_tx_modulator.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pdm_tx_modulator_if.sv
// PCM sample handshake between a sample source (master) and the PDM transmitter (slave).
interface pdm_tx_modulator_if #(
  parameter int unsigned SAMPLE_WIDTH = 8
) ();
  logic signed [SAMPLE_WIDTH-1:0] sample_in;
  logic                           valid_in;
  logic                           ready_out;

  modport master (output sample_in, output valid_in, input ready_out);
  modport slave  (input sample_in, input valid_in, output ready_out);
endinterface

// File: rtl/pdm_tx_modulator.sv
// PCM-to-PDM transmitter: bit clock divider, sample FIFO and first-order delta-sigma modulator.
module pdm_tx_modulator #(
  parameter int unsigned PDM_COUNT_PERIOD = 16,
  parameter int unsigned OSR              = 128,
  parameter int unsigned SAMPLE_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  pdm_tx_modulator_if.slave s_if,
  output logic              pdm_clk_out,
  output logic              pdm_out,
  output logic              pdm_step_out,
  output logic              sample_step_out,
  output logic              underflow_out
);

  localparam int unsigned CNT_W  = $clog2(PDM_COUNT_PERIOD);
  localparam int unsigned BIT_W  = $clog2(OSR);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_cnt_next;
  logic [BIT_W-1:0]               r_bit_cnt;
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [FCNT_W-1:0]              r_count;
  logic [FCNT_W-1:0]              w_count_next;
  logic signed [SAMPLE_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic signed [SAMPLE_WIDTH-1:0] r_cur;
  logic [SAMPLE_WIDTH-1:0]        r_acc;
  logic [SAMPLE_WIDTH-1:0]        w_u;
  logic [SAMPLE_WIDTH:0]          w_sum;
  logic                           r_clk;
  logic                           r_step;
  logic                           r_pdm;
  logic                           r_sstep;
  logic                           r_uf;
  logic                           r_ready;
  logic                           w_push;
  logic                           w_bound;
  logic                           w_empty;
  logic                           w_pop;
  logic                           w_bypass;
  logic                           w_fifo_wr;

  // Next-cycle counters, handshake decode and modulator sum.
  always_comb begin
    w_cnt_next   = (r_cnt == CNT_W'(PDM_COUNT_PERIOD - 1)) ? '0 : r_cnt + CNT_W'(1);
    w_push       = s_if.valid_in && r_ready;
    w_bound      = r_step && (r_bit_cnt == BIT_W'(OSR - 1));
    w_empty      = (r_count == '0);
    w_pop        = w_bound && !w_empty;
    // An empty FIFO hands a sample arriving on the boundary edge straight to the modulator.
    w_bypass     = w_bound && w_empty && w_push;
    w_fifo_wr    = w_push && !w_bypass;
    w_count_next = r_count + FCNT_W'(w_fifo_wr) - FCNT_W'(w_pop);
    // Offset binary: flipping the sign bit adds 2^(SAMPLE_WIDTH-1).
    w_u          = {~r_cur[SAMPLE_WIDTH-1], r_cur[SAMPLE_WIDTH-2:0]};
    w_sum        = {1'b0, r_acc} + {1'b0, w_u};
  end

  // Bit clock, FIFO bookkeeping, sample load and delta-sigma state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_cur     <= '0;
      r_acc     <= '0;
      r_clk     <= 1'b0;
      r_step    <= 1'b0;
      r_pdm     <= 1'b0;
      r_sstep   <= 1'b0;
      r_uf      <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_clk   <= (w_cnt_next < CNT_W'(PDM_COUNT_PERIOD / 2));
      r_step  <= (w_cnt_next == CNT_W'(PDM_COUNT_PERIOD - 1));
      r_count <= w_count_next;
      r_ready <= (w_count_next < FCNT_W'(FIFO_DEPTH));
      r_sstep <= w_pop || w_bypass;
      r_uf    <= w_bound && w_empty && !w_push;
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_cur    <= r_fifo[r_rd_ptr];
      end else if (w_bypass) begin
        r_cur <= s_if.sample_in;
      end
      // The boundary bit still uses the old sample: w_sum is built from r_cur before the load.
      if (r_step) begin
        r_bit_cnt <= (r_bit_cnt == BIT_W'(OSR - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
        r_acc     <= w_sum[SAMPLE_WIDTH-1:0];
        r_pdm     <= w_sum[SAMPLE_WIDTH];
      end
    end
  end

  // Sample storage; contents need no reset since pointers and count gate every read.
  always_ff @(posedge clk_in) begin
    if (w_fifo_wr) begin
      r_fifo[r_wr_ptr] <= s_if.sample_in;
    end
  end

  assign s_if.ready_out   = r_ready;
  assign pdm_clk_out      = r_clk;
  assign pdm_out          = r_pdm;
  assign pdm_step_out     = r_step;
  assign sample_step_out  = r_sstep;
  assign underflow_out    = r_uf;

endmodule
